// File: rtl/guess_compare_ctrl_if.sv
// Handshake bundle between the guessing-game controller and the player/display
// side: game start, secret/guess operands, guess handshake and result flags.
interface guess_compare_ctrl_if #(
  parameter int WIDTH = 10
);
  logic             start;
  logic [WIDTH-1:0] secret_in;
  logic [WIDTH-1:0] guess_in;
  logic             guess_valid;
  logic             guess_ready;
  logic             result_valid;
  logic             higher;
  logic             lower;
  logic             win;
  logic             lose;
  logic [3:0]       tries_left;

  // Player / display side: offers games and guesses, observes results.
  modport master (
    output start, secret_in, guess_in, guess_valid,
    input  guess_ready, result_valid, higher, lower, win, lose, tries_left
  );

  // Controller side.
  modport slave (
    input  start, secret_in, guess_in, guess_valid,
    output guess_ready, result_valid, higher, lower, win, lose, tries_left
  );
endinterface

// File: rtl/guess_compare_ctrl.sv
// Number-guessing game sequencer. One unsigned "A > B" comparator is shared
// over two cycles: first guess > secret, then secret > guess. Both false means
// the guess is correct. All outputs are registered.
module guess_compare_ctrl #(
  parameter int WIDTH     = 10,
  parameter int MAX_TRIES = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  guess_compare_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GUESS,
    CMP_HI,
    CMP_LO,
    RESULT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] secret_reg;
  logic [WIDTH-1:0] guess_reg;
  logic             gt_reg;

  logic             ready_q;
  logic             result_valid_q;
  logic             higher_q;
  logic             lower_q;
  logic             win_q;
  logic             lose_q;
  logic [3:0]       tries_q;

  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic             cmp_gt;

  // Single shared comparator; operands swap in CMP_LO so its output means "lt".
  always_comb begin
    cmp_a = guess_reg;
    cmp_b = secret_reg;
    if (state == CMP_LO) begin
      cmp_a = secret_reg;
      cmp_b = guess_reg;
    end
    cmp_gt = (cmp_a > cmp_b);
  end

  // Game FSM with registered outputs; start preempts every state.
  // NOTE: all state here is assigned with <= so every register samples the
  // pre-edge values of the others; a blocking = would chain them in one cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      secret_reg     <= '0;
      guess_reg      <= '0;
      gt_reg         <= 1'b0;
      ready_q        <= 1'b0;
      result_valid_q <= 1'b0;
      higher_q       <= 1'b0;
      lower_q        <= 1'b0;
      win_q          <= 1'b0;
      lose_q         <= 1'b0;
      tries_q        <= 4'd0;
    end else if (bus.start) begin
      // New game; any guess in flight is dropped without a result pulse.
      state          <= WAIT_GUESS;
      secret_reg     <= bus.secret_in;
      guess_reg      <= '0;
      gt_reg         <= 1'b0;
      ready_q        <= 1'b1;
      result_valid_q <= 1'b0;
      higher_q       <= 1'b0;
      lower_q        <= 1'b0;
      win_q          <= 1'b0;
      lose_q         <= 1'b0;
      tries_q        <= 4'(MAX_TRIES);
    end else begin
      case (state)
        IDLE: begin
          // Waiting for the first start; guesses are ignored.
        end
        WAIT_GUESS: begin
          if (bus.guess_valid) begin
            guess_reg <= bus.guess_in;
            tries_q   <= tries_q - 4'd1;
            higher_q  <= 1'b0;
            lower_q   <= 1'b0;
            ready_q   <= 1'b0;
            state     <= CMP_HI;
          end
        end
        CMP_HI: begin
          gt_reg <= cmp_gt;
          state  <= CMP_LO;
        end
        CMP_LO: begin
          // Flags are loaded on the way into RESULT so they are visible
          // in the same cycle as result_valid.
          lower_q        <= gt_reg;
          higher_q       <= cmp_gt;
          result_valid_q <= 1'b1;
          if (!gt_reg && !cmp_gt) begin
            win_q <= 1'b1;
          end else if (tries_q == 4'd0) begin
            lose_q <= 1'b1;
          end
          state <= RESULT;
        end
        RESULT: begin
          result_valid_q <= 1'b0;
          if (win_q || lose_q) begin
            state <= DONE;
          end else begin
            ready_q <= 1'b1;
            state   <= WAIT_GUESS;
          end
        end
        DONE: begin
          // Hold everything until start or reset.
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.guess_ready  = ready_q;
  assign bus.result_valid = result_valid_q;
  assign bus.higher       = higher_q;
  assign bus.lower        = lower_q;
  assign bus.win          = win_q;
  assign bus.lose         = lose_q;
  assign bus.tries_left   = tries_q;

endmodule

// File: tb/tb_guess_compare_ctrl.sv
// Directed bench for guess_compare_ctrl: reset, a full winning game, a losing
// game, start preemption mid-compare, and operand boundary values.
module tb_guess_compare_ctrl;

  localparam int WIDTH = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  int checks = 0;
  int failures = 0;

  guess_compare_ctrl_if #(.WIDTH(WIDTH)) bus ();

  guess_compare_ctrl #(.WIDTH(WIDTH), .MAX_TRIES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Pulse start for one cycle; returns at the negedge of cycle S+1.
  task automatic do_start(input logic [WIDTH-1:0] secret);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.secret_in = secret;
    @(negedge clk);
    bus.start     = 1'b0;
  endtask

  // Offer a guess once ready; returns at the negedge where result_valid is
  // seen (lat = cycles after accepting edge) or lat = -1 on timeout.
  task automatic send_guess(input logic [WIDTH-1:0] g, output int lat);
    int n;
    lat = -1;
    n = 0;
    while (!bus.guess_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.guess_ready) return;
    bus.guess_valid = 1'b1;
    bus.guess_in    = g;
    @(negedge clk);
    bus.guess_valid = 1'b0;
    bus.guess_in    = '1;
    n = 1;
    while (!bus.result_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (bus.result_valid) lat = n;
  endtask

  task automatic test_reset();
    bus.start       = 1'b1;
    bus.secret_in   = 10'd77;
    bus.guess_valid = 1'b1;
    bus.guess_in    = 10'd3;
    reset_n         = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.guess_ready, bus.result_valid, bus.higher, bus.lower, bus.win, bus.lose} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=000000",
               {bus.guess_ready, bus.result_valid, bus.higher, bus.lower, bus.win, bus.lose});
    end
    checks++;
    if (bus.tries_left !== 4'd0) begin
      failures++;
      $display("FAIL reset_tries got=%0d want=0", bus.tries_left);
    end
    bus.start = 1'b0;
    reset_n   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.result_valid !== 1'b0 || bus.guess_ready !== 1'b0) begin
        failures++;
        $display("FAIL idle_ignores_guess cyc=%0d rv=%b rdy=%b want rv=0 rdy=0",
                 i, bus.result_valid, bus.guess_ready);
      end
    end
    bus.guess_valid = 1'b0;
  endtask

  task automatic test_game_win();
    int lat;
    do_start(10'b0010011101);
    checks++;
    if (bus.guess_ready !== 1'b1 || bus.tries_left !== 4'd10) begin
      failures++;
      $display("FAIL start_state rdy=%b tries=%0d want rdy=1 tries=10", bus.guess_ready, bus.tries_left);
    end
    send_guess(10'b1110011101, lat);
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("FAIL latency_925 got=%0d want=3", lat);
    end
    checks++;
    if ({bus.higher, bus.lower, bus.win, bus.lose} !== 4'b0100 || bus.tries_left !== 4'd9) begin
      failures++;
      $display("FAIL guess_925 hlwL=%b tries=%0d want hlwL=0100 tries=9",
               {bus.higher, bus.lower, bus.win, bus.lose}, bus.tries_left);
    end
    @(negedge clk);
    checks++;
    if (bus.result_valid !== 1'b0 || bus.guess_ready !== 1'b1) begin
      failures++;
      $display("FAIL after_result rv=%b rdy=%b want rv=0 rdy=1", bus.result_valid, bus.guess_ready);
    end
    send_guess(10'd0, lat);
    checks++;
    if (lat !== 3 || {bus.higher, bus.lower, bus.win, bus.lose} !== 4'b1000 || bus.tries_left !== 4'd8) begin
      failures++;
      $display("FAIL guess_0 lat=%0d hlwL=%b tries=%0d want lat=3 hlwL=1000 tries=8",
               lat, {bus.higher, bus.lower, bus.win, bus.lose}, bus.tries_left);
    end
    send_guess(10'd157, lat);
    checks++;
    if (lat !== 3 || {bus.higher, bus.lower, bus.win, bus.lose} !== 4'b0010 || bus.tries_left !== 4'd7) begin
      failures++;
      $display("FAIL guess_157 lat=%0d hlwL=%b tries=%0d want lat=3 hlwL=0010 tries=7",
               lat, {bus.higher, bus.lower, bus.win, bus.lose}, bus.tries_left);
    end
    bus.guess_valid = 1'b1;
    bus.guess_in    = 10'd5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.guess_ready !== 1'b0 || bus.result_valid !== 1'b0 || bus.win !== 1'b1 || bus.tries_left !== 4'd7) begin
        failures++;
        $display("FAIL done_hold cyc=%0d rdy=%b rv=%b win=%b tries=%0d want 0 0 1 7",
                 i, bus.guess_ready, bus.result_valid, bus.win, bus.tries_left);
      end
    end
    bus.guess_valid = 1'b0;
  endtask

  task automatic test_lose();
    int lat;
    do_start(10'd0);
    for (int i = 0; i < 10; i++) begin
      send_guess(10'b1100000000, lat);
      checks++;
      if (lat !== 3 || bus.lower !== 1'b1 || bus.higher !== 1'b0 || bus.tries_left !== 4'(9 - i)) begin
        failures++;
        $display("FAIL lose_guess n=%0d lat=%0d lower=%b higher=%b tries=%0d want lat=3 1 0 %0d",
                 i, lat, bus.lower, bus.higher, bus.tries_left, 9 - i);
      end
    end
    checks++;
    if (bus.lose !== 1'b1 || bus.win !== 1'b0 || bus.tries_left !== 4'd0) begin
      failures++;
      $display("FAIL lose_final lose=%b win=%b tries=%0d want 1 0 0", bus.lose, bus.win, bus.tries_left);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.guess_ready !== 1'b0 || bus.lose !== 1'b1 || bus.win !== 1'b0) begin
      failures++;
      $display("FAIL lose_hold rdy=%b lose=%b win=%b want 0 1 0", bus.guess_ready, bus.lose, bus.win);
    end
  endtask

  task automatic test_start_abort();
    int lat;
    do_start(10'd100);
    // Cycle E: offer the guess; accepted at the next edge.
    bus.guess_valid = 1'b1;
    bus.guess_in    = 10'd3;
    @(negedge clk);            // E+1, CMP_HI
    bus.guess_valid = 1'b0;
    @(negedge clk);            // E+2, CMP_LO
    bus.start     = 1'b1;
    bus.secret_in = 10'd5;
    @(negedge clk);            // E+3, would have been RESULT
    bus.start = 1'b0;
    checks++;
    if (bus.result_valid !== 1'b0 || bus.tries_left !== 4'd10 || bus.guess_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_state rv=%b tries=%0d rdy=%b want 0 10 1",
               bus.result_valid, bus.tries_left, bus.guess_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.result_valid !== 1'b0) begin
        failures++;
        $display("FAIL abort_no_result cyc=%0d rv=%b want 0", i, bus.result_valid);
      end
    end
    send_guess(10'd5, lat);
    checks++;
    if (lat !== 3 || bus.win !== 1'b1 || bus.tries_left !== 4'd9) begin
      failures++;
      $display("FAIL abort_then_win lat=%0d win=%b tries=%0d want 3 1 9", lat, bus.win, bus.tries_left);
    end
  endtask

  task automatic test_boundary();
    int lat;
    logic [WIDTH-1:0] secrets [3] = '{10'd1023, 10'd1023, 10'd0};
    logic [WIDTH-1:0] guesses [3] = '{10'd1023, 10'd1022, 10'd0};
    logic [3:0]       want    [3] = '{4'b0010, 4'b1000, 4'b0010};
    for (int i = 0; i < 3; i++) begin
      do_start(secrets[i]);
      send_guess(guesses[i], lat);
      checks++;
      if (lat !== 3 || {bus.higher, bus.lower, bus.win, bus.lose} !== want[i]) begin
        failures++;
        $display("FAIL boundary s=%0d g=%0d lat=%0d hlwL=%b want lat=3 hlwL=%b",
                 secrets[i], guesses[i], lat, {bus.higher, bus.lower, bus.win, bus.lose}, want[i]);
      end
    end
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.secret_in   = '0;
    bus.guess_in    = '0;
    bus.guess_valid = 1'b0;
    test_reset();
    test_game_win();
    test_lose();
    test_start_abort();
    test_boundary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
